// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path:
// opcodes, ALUOp codes, FSM state encoding and datapath select codes.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  localparam logic [2:0] ALUOP_ADD   = 3'd0;
  localparam logic [2:0] ALUOP_SUB   = 3'd1;
  localparam logic [2:0] ALUOP_RTYPE = 3'd2;
  localparam logic [2:0] ALUOP_ADDI  = 3'd3;
  localparam logic [2:0] ALUOP_ORI   = 3'd4;
  localparam logic [2:0] ALUOP_LUI   = 3'd5;

  localparam logic [3:0] ST_FETCH     = 4'd0;
  localparam logic [3:0] ST_DECODE    = 4'd1;
  localparam logic [3:0] ST_MEM_ADDR  = 4'd2;
  localparam logic [3:0] ST_MEM_READ  = 4'd3;
  localparam logic [3:0] ST_MEM_WB    = 4'd4;
  localparam logic [3:0] ST_MEM_WRITE = 4'd5;
  localparam logic [3:0] ST_R_EXEC    = 4'd6;
  localparam logic [3:0] ST_R_WB      = 4'd7;
  localparam logic [3:0] ST_I_EXEC    = 4'd8;
  localparam logic [3:0] ST_I_WB      = 4'd9;
  localparam logic [3:0] ST_BRANCH    = 4'd10;
  localparam logic [3:0] ST_JUMP      = 4'd11;
  localparam logic [3:0] ST_JR        = 4'd12;
  localparam logic [3:0] ST_HALT      = 4'd13;

  typedef enum logic [3:0] {
    FETCH     = ST_FETCH,
    DECODE    = ST_DECODE,
    MEM_ADDR  = ST_MEM_ADDR,
    MEM_READ  = ST_MEM_READ,
    MEM_WB    = ST_MEM_WB,
    MEM_WRITE = ST_MEM_WRITE,
    R_EXEC    = ST_R_EXEC,
    R_WB      = ST_R_WB,
    I_EXEC    = ST_I_EXEC,
    I_WB      = ST_I_WB,
    BRANCH    = ST_BRANCH,
    JUMP      = ST_JUMP,
    JR        = ST_JR,
    HALT      = ST_HALT
  } state_t;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_IMMSH = 2'd3;

  localparam logic [1:0] REGDST_RT = 2'd0;
  localparam logic [1:0] REGDST_RD = 2'd1;
  localparam logic [1:0] REGDST_RA = 2'd2;

  localparam logic [1:0] M2R_ALU = 2'd0;
  localparam logic [1:0] M2R_MDR = 2'd1;
  localparam logic [1:0] M2R_PC  = 2'd2;

  // Bit positions of the one-hot instruction class
  localparam int CLS_MEM = 0;
  localparam int CLS_R   = 1;
  localparam int CLS_JR  = 2;
  localparam int CLS_IMM = 3;
  localparam int CLS_BR  = 4;
  localparam int CLS_JMP = 5;
  localparam int CLS_ILL = 6;
  localparam int NUM_CLS = 7;

  function automatic logic [2:0] immAluOp(input logic [5:0] op);
    case (op)
      OP_ORI:  return ALUOP_ORI;
      OP_LUI:  return ALUOP_LUI;
      default: return ALUOP_ADDI;
    endcase
  endfunction

endpackage

// File: rtl/mc_opcode_decoder.sv
// Classifies an instruction into a one-hot class from OP/Funct.
// Ports: OP, Funct in; opClass out (bit positions CLS_* in the package).
module mc_opcode_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0]         OP,
  input  logic [5:0]         Funct,
  output logic [NUM_CLS-1:0] opClass
);

  always_comb begin
    opClass = '0;
    unique case (OP)
      OP_LW, OP_SW:
        opClass[CLS_MEM] = 1'b1;
      OP_RTYPE:
        if (Funct == FUNCT_JR) opClass[CLS_JR] = 1'b1;
        else opClass[CLS_R] = 1'b1;
      OP_ADDI, OP_ORI, OP_LUI:
        opClass[CLS_IMM] = 1'b1;
      OP_BEQ, OP_BNE:
        opClass[CLS_BR] = 1'b1;
      OP_J, OP_JAL:
        opClass[CLS_JMP] = 1'b1;
      default:
        opClass[CLS_ILL] = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle MIPS main sequencer: steps each instruction through its
// states and drives datapath enables/selects; stalls on MemReady.
// Ports: clk, reset (sync, active-low), OP, Funct, Zero, MemReady in;
// PCWrite, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
// ALUSrcA, ALUSrcB, ALUOp, PCSource, InstrRetired, Halted out.
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OP,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       InstrRetired,
  output logic       Halted
);

  state_t             state;
  state_t             nextState;
  logic [5:0]         opReg;
  logic [NUM_CLS-1:0] opClass;

  mc_opcode_decoder uDec (
    .OP      (OP),
    .Funct   (Funct),
    .opClass (opClass)
  );

  // OP is captured in DECODE so later states never look at the IR
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      opReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) opReg <= OP;
    end
  end

  always_comb begin
    nextState    = state;
    PCWrite      = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = REGDST_RT;
    MemtoReg     = M2R_ALU;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = SRCB_RT;
    ALUOp        = ALUOP_ADD;
    PCSource     = PCSRC_ALU;
    InstrRetired = 1'b0;
    Halted       = 1'b0;
    // Reset forces every output low, aborting any in-flight write
    if (reset) begin
      unique case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = SRCB_FOUR;
          if (MemReady) begin
            PCWrite   = 1'b1;
            IRWrite   = 1'b1;
            nextState = DECODE;
          end
        end
        DECODE: begin
          ALUSrcB = SRCB_IMMSH;
          unique case (1'b1)
            opClass[CLS_MEM]: nextState = MEM_ADDR;
            opClass[CLS_R]:   nextState = R_EXEC;
            opClass[CLS_JR]:  nextState = JR;
            opClass[CLS_IMM]: nextState = I_EXEC;
            opClass[CLS_BR]:  nextState = BRANCH;
            opClass[CLS_JMP]: nextState = JUMP;
            default: begin
              if (ILLEGAL_TRAP) begin
                nextState = HALT;
              end else begin
                InstrRetired = 1'b1;
                nextState    = FETCH;
              end
            end
          endcase
        end
        MEM_ADDR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_IMM;
          nextState = (opReg == OP_LW) ? MEM_READ : MEM_WRITE;
        end
        MEM_READ: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
          if (MemReady) nextState = MEM_WB;
        end
        MEM_WB: begin
          MemtoReg     = M2R_MDR;
          RegWrite     = 1'b1;
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
          if (MemReady) begin
            InstrRetired = 1'b1;
            nextState    = FETCH;
          end
        end
        R_EXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = ALUOP_RTYPE;
          nextState = R_WB;
        end
        R_WB: begin
          RegDst       = REGDST_RD;
          RegWrite     = 1'b1;
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        I_EXEC: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = SRCB_IMM;
          ALUOp     = immAluOp(opReg);
          nextState = I_WB;
        end
        I_WB: begin
          ALUOp        = immAluOp(opReg);
          RegWrite     = 1'b1;
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        BRANCH: begin
          ALUSrcA      = 1'b1;
          ALUOp        = ALUOP_SUB;
          PCSource     = PCSRC_ALUOUT;
          PCWrite      = (opReg == OP_BEQ) ? Zero : ~Zero;
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        JUMP: begin
          PCSource = PCSRC_JUMP;
          PCWrite  = 1'b1;
          if (opReg == OP_JAL) begin
            RegDst   = REGDST_RA;
            MemtoReg = M2R_PC;
            RegWrite = 1'b1;
          end
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        JR: begin
          ALUSrcA      = 1'b1;
          PCSource     = PCSRC_RS;
          PCWrite      = 1'b1;
          InstrRetired = 1'b1;
          nextState    = FETCH;
        end
        HALT: begin
          Halted    = 1'b1;
          nextState = HALT;
        end
        default: nextState = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed and random instructions
// against a per-instruction cycle plan built from the control rules.
module tb_multicycle_control_fsm;
  import mips_ctrl_pkg::*;

  typedef struct packed {
    logic       pcw;
    logic       iord;
    logic       mr;
    logic       mw;
    logic       irw;
    logic [1:0] rd;
    logic [1:0] m2r;
    logic       rw;
    logic       sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] ps;
    logic       ret;
    logic       hlt;
  } outs_t;

  typedef struct {
    logic  rdy;
    outs_t e;
  } step_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       Zero = 1'b0;
  logic       MemReady = 1'b0;
  logic [5:0] OP = '0;
  logic [5:0] Funct = '0;

  logic       pcw[2], iord[2], mr[2], mw[2], irw[2];
  logic       rw[2], sa[2], ret[2], hlt[2];
  logic [1:0] rd[2], m2r[2], sb[2], ps[2];
  logic [2:0] alu[2];

  int errors = 0;
  int checks = 0;
  step_t plan[$];
  logic [5:0] legalOps[10] = '{OP_RTYPE, OP_LW, OP_SW, OP_ADDI,
    OP_ORI, OP_LUI, OP_BEQ, OP_BNE, OP_J, OP_JAL};

  always #5 clk = ~clk;

  // index 0: NOP on illegal opcode, index 1: trap on illegal opcode
  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b0)) dutN (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady),
    .PCWrite(pcw[0]), .IorD(iord[0]), .MemRead(mr[0]),
    .MemWrite(mw[0]), .IRWrite(irw[0]), .RegDst(rd[0]),
    .MemtoReg(m2r[0]), .RegWrite(rw[0]), .ALUSrcA(sa[0]),
    .ALUSrcB(sb[0]), .ALUOp(alu[0]), .PCSource(ps[0]),
    .InstrRetired(ret[0]), .Halted(hlt[0])
  );

  multicycle_control_fsm #(.ILLEGAL_TRAP(1'b1)) dutT (
    .clk(clk), .reset(reset), .OP(OP), .Funct(Funct),
    .Zero(Zero), .MemReady(MemReady),
    .PCWrite(pcw[1]), .IorD(iord[1]), .MemRead(mr[1]),
    .MemWrite(mw[1]), .IRWrite(irw[1]), .RegDst(rd[1]),
    .MemtoReg(m2r[1]), .RegWrite(rw[1]), .ALUSrcA(sa[1]),
    .ALUSrcB(sb[1]), .ALUOp(alu[1]), .PCSource(ps[1]),
    .InstrRetired(ret[1]), .Halted(hlt[1])
  );

  function automatic outs_t got(input int i);
    outs_t g;
    g = '{pcw[i], iord[i], mr[i], mw[i], irw[i], rd[i], m2r[i],
          rw[i], sa[i], sb[i], alu[i], ps[i], ret[i], hlt[i]};
    return g;
  endfunction

  task automatic check(input string tag, input int i, input outs_t exp);
    outs_t g;
    g = got(i);
    checks++;
    assert (g === exp) else begin
      errors++;
      $error("FAIL %s dut%0d got=%h exp=%h", tag, i, g, exp);
    end
    checks++;
    assert (!(g.mr && g.mw)) else begin
      errors++;
      $error("FAIL %s dut%0d MemRead&MemWrite got=1 exp=0", tag, i);
    end
  endtask

  function automatic void push(input logic rdy, input outs_t e);
    step_t s;
    s.rdy = rdy;
    s.e = e;
    plan.push_back(s);
  endfunction

  function automatic logic anyRdy();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t fetchOut(input logic done);
    outs_t e = '0;
    e.mr = 1'b1;
    e.sb = SRCB_FOUR;
    e.alu = ALUOP_ADD;
    e.pcw = done;
    e.irw = done;
    return e;
  endfunction

  // Expected cycle plan of one instruction from the control rules
  function automatic void buildPlan(input logic [5:0] op,
      input logic [5:0] fn, input logic z, input int fSt, input int mSt);
    outs_t e;
    plan.delete();
    for (int i = 0; i < fSt; i++) push(1'b0, fetchOut(1'b0));
    push(1'b1, fetchOut(1'b1));
    e = '0;
    e.sb = SRCB_IMMSH;
    e.alu = ALUOP_ADD;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_ORI, OP_LUI,
      OP_BEQ, OP_BNE, OP_J, OP_JAL: push(anyRdy(), e);
      default: begin
        e.ret = 1'b1;
        push(anyRdy(), e);
        return;
      end
    endcase
    e = '0;
    case (op)
      OP_LW, OP_SW: begin
        e.sa = 1'b1;
        e.sb = SRCB_IMM;
        e.alu = ALUOP_ADD;
        push(anyRdy(), e);
        e = '0;
        e.iord = 1'b1;
        e.mr = (op == OP_LW);
        e.mw = (op == OP_SW);
        for (int i = 0; i < mSt; i++) push(1'b0, e);
        e.ret = (op == OP_SW);
        push(1'b1, e);
        if (op == OP_LW) begin
          e = '0;
          e.m2r = M2R_MDR;
          e.rw = 1'b1;
          e.ret = 1'b1;
          push(anyRdy(), e);
        end
      end
      OP_RTYPE: begin
        e.sa = 1'b1;
        if (fn == FUNCT_JR) begin
          e.ps = PCSRC_RS;
          e.pcw = 1'b1;
          e.ret = 1'b1;
          push(anyRdy(), e);
        end else begin
          e.alu = ALUOP_RTYPE;
          push(anyRdy(), e);
          e = '0;
          e.rd = REGDST_RD;
          e.rw = 1'b1;
          e.ret = 1'b1;
          push(anyRdy(), e);
        end
      end
      OP_ADDI, OP_ORI, OP_LUI: begin
        e.sa = 1'b1;
        e.sb = SRCB_IMM;
        e.alu = (op == OP_ADDI) ? ALUOP_ADDI :
                (op == OP_ORI) ? ALUOP_ORI : ALUOP_LUI;
        push(anyRdy(), e);
        e.sa = 1'b0;
        e.sb = SRCB_RT;
        e.rw = 1'b1;
        e.ret = 1'b1;
        push(anyRdy(), e);
      end
      OP_BEQ, OP_BNE: begin
        e.sa = 1'b1;
        e.alu = ALUOP_SUB;
        e.ps = PCSRC_ALUOUT;
        e.pcw = (op == OP_BEQ) ? z : !z;
        e.ret = 1'b1;
        push(anyRdy(), e);
      end
      default: begin
        e.ps = PCSRC_JUMP;
        e.pcw = 1'b1;
        e.ret = 1'b1;
        if (op == OP_JAL) begin
          e.rd = REGDST_RA;
          e.m2r = M2R_PC;
          e.rw = 1'b1;
        end
        push(anyRdy(), e);
      end
    endcase
  endfunction

  task automatic doReset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b0;
      MemReady = anyRdy();
      OP = 6'($urandom_range(0, 63));
      #1;
      check("reset", 0, '0);
      check("reset", 1, '0);
    end
  endtask

  task automatic runInstr(input string name, input logic [5:0] op,
      input logic [5:0] fn, input logic z, input int fSt, input int mSt,
      input int abortAt);
    buildPlan(op, fn, z, fSt, mSt);
    foreach (plan[k]) begin
      @(negedge clk);
      if (k == abortAt) begin
        reset = 1'b0;
        MemReady = 1'b0;
        #1;
        check($sformatf("%s abort", name), 0, '0);
        check($sformatf("%s abort", name), 1, '0);
        return;
      end
      reset = 1'b1;
      if (k == 0) begin
        OP = op;
        Funct = fn;
        Zero = z;
      end
      MemReady = plan[k].rdy;
      #1;
      check($sformatf("%s c%0d", name, k + 1), 0, plan[k].e);
      check($sformatf("%s c%0d", name, k + 1), 1, plan[k].e);
    end
  endtask

  initial begin
    outs_t e;
    doReset(2);
    runInstr("add", OP_RTYPE, 6'h20, 1'b0, 0, 0, -1);
    runInstr("lwStall", OP_LW, 6'h00, 1'b0, 0, 3, -1);
    runInstr("lwFetchStall", OP_LW, 6'h11, 1'b0, 2, 0, -1);
    runInstr("beqTaken", OP_BEQ, 6'h00, 1'b1, 0, 0, -1);
    runInstr("beqNot", OP_BEQ, 6'h00, 1'b0, 0, 0, -1);
    runInstr("bneTaken", OP_BNE, 6'h00, 1'b0, 0, 0, -1);
    runInstr("bneNot", OP_BNE, 6'h00, 1'b1, 0, 0, -1);
    runInstr("jal", OP_JAL, 6'h00, 1'b0, 0, 0, -1);
    runInstr("j", OP_J, 6'h08, 1'b0, 0, 0, -1);
    runInstr("jr", OP_RTYPE, FUNCT_JR, 1'b0, 0, 0, -1);
    runInstr("addi", OP_ADDI, 6'h00, 1'b0, 0, 0, -1);
    runInstr("ori", OP_ORI, 6'h00, 1'b0, 1, 0, -1);
    runInstr("lui", OP_LUI, 6'h00, 1'b0, 0, 0, -1);
    runInstr("swStall", OP_SW, 6'h00, 1'b0, 0, 2, -1);

    // Illegal opcode: trap variant parks in HALT, NOP variant retires
    @(negedge clk);
    reset = 1'b1;
    OP = 6'h3F;
    MemReady = 1'b1;
    #1;
    check("ill fetch", 0, fetchOut(1'b1));
    check("ill fetch", 1, fetchOut(1'b1));
    @(negedge clk);
    MemReady = 1'b0;
    #1;
    e = '0;
    e.sb = SRCB_IMMSH;
    check("ill decode trap", 1, e);
    e.ret = 1'b1;
    check("ill decode nop", 0, e);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      MemReady = anyRdy();
      #1;
      e = '0;
      e.hlt = 1'b1;
      check($sformatf("halt c%0d", i + 3), 1, e);
      if (i == 0) check("nop refetch", 0, fetchOut(MemReady));
    end
    doReset(1);
    runInstr("postHalt", OP_ORI, 6'h00, 1'b0, 0, 0, -1);

    // Reset in the middle of a MEM_WRITE stall
    runInstr("swAbort", OP_SW, 6'h00, 1'b0, 0, 3, 4);
    runInstr("afterAbort", OP_RTYPE, 6'h22, 1'b0, 1, 0, -1);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = legalOps[$urandom_range(0, 9)];
      fn = 6'($urandom_range(0, 63));
      if (op == OP_RTYPE && $urandom_range(0, 3) == 0) fn = FUNCT_JR;
      runInstr($sformatf("rnd%0d", n), op, fn, 1'($urandom_range(0, 1)),
        $urandom_range(0, 2), $urandom_range(0, 3), -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
